// File: rtl/decoder_scan.sv
// -----------------------------------------------------------------------------
// decoder_scan
//   Registered N-to-2**N line decoder with run-time output polarity, an output
//   enable and an auto-scan mode that walks a single active output through all
//   2**N lines, holding each one for dwell+1 cycles. Intended to drive strobe /
//   select lines of multiplexed displays and row scanners.
//
// Parameters
//   N   select width, output width is 2**N (1..6)
//   DW  dwell counter width
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   a           in   [N]    select value captured on load
//   load        in   capture a into the select register (beats scan)
//   scan        in   auto-scan mode request
//   dwell       in   [DW]   extra cycles each output stays active while scanning
//   enable      in   0 forces all outputs inactive on the next edge
//   active_low  in   output polarity, 1 = active-low (combinational)
//   y           out  [2**N] decoded outputs
//   sel         out  [N]    current select register value
//   wrap        out  one-cycle pulse when a scan steps from 2**N-1 to 0
//   state       out  debug view of the FSM: 0 = HOLD, 1 = SCAN
//
// Handshake: there is no valid/ready pair; every output is a plain registered
// level (except the polarity XOR on y) and is meaningful on every cycle.
// -----------------------------------------------------------------------------
module decoder_scan #(
    parameter int N  = 2,
    parameter int DW = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      a,
    input  logic              load,
    input  logic              scan,
    input  logic [DW-1:0]     dwell,
    input  logic              enable,
    input  logic              active_low,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      sel,
    output logic              wrap,
    output logic              state
);

    localparam int W = 2**N;

    typedef enum logic {
        HOLD = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sel_q, sel_d;
    logic [W-1:0]   onehot_q, onehot_d;
    logic [DW-1:0]  cnt, cnt_d;
    logic           wrap_q, wrap_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HOLD;
            sel_q    <= '0;
            onehot_q <= '0;
            cnt      <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            cnt      <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt;
        wrap_d   = 1'b0;
        onehot_d = '0;

        if (load) begin
            sel_d   = a;
            cnt_d   = '0;
            state_d = HOLD;
        end else if (scan) begin
            if (state_q == HOLD) begin
                // Entering scan restarts the dwell count so the output that is
                // already showing gets a full dwell period before the first step.
                state_d = SCAN;
                cnt_d   = '0;
            end else if (cnt >= dwell) begin
                // >= rather than == so a dwell lowered below the running count
                // advances immediately instead of waiting for cnt to roll over.
                sel_d  = sel_q + N'(1);
                cnt_d  = '0;
                wrap_d = (sel_q == {N{1'b1}});
            end else begin
                cnt_d = cnt + DW'(1);
            end
        end else begin
            state_d = HOLD;
        end

        // The line pattern follows the next select value, so it is in step with
        // sel on the same edge. With enable low the select keeps moving unseen.
        if (enable) begin
            onehot_d[sel_d] = 1'b1;
        end
    end

    assign y     = onehot_q ^ {W{active_low}};
    assign sel   = sel_q;
    assign wrap  = wrap_q;
    assign state = (state_q == SCAN);

endmodule

// File: tb/tb_decoder_scan.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan
//   Directed bench for decoder_scan. Two instances share the stimulus: one with
//   N=2 and one with N=3. Each queue entry names the instance it checks.
//   Entry layout: [13] instance (0: N=2, 1: N=3), [12] state, [11] wrap,
//   [10:8] sel, [7:0] y.
// -----------------------------------------------------------------------------
module tb_decoder_scan;

    logic        clock;
    logic        reset;
    logic [2:0]  a_in;
    logic        load;
    logic        scan;
    logic [3:0]  dwell;
    logic        enable;
    logic        active_low;

    logic [3:0]  y2;
    logic [1:0]  sel2;
    logic        wrap2;
    logic        st2;
    logic [7:0]  y3;
    logic [2:0]  sel3;
    logic        wrap3;
    logic        st3;

    int tests = 0;
    int fails = 0;
    int ntag  = 0;

    logic [13:0] exp_q[$];
    int          tag_q[$];
    event        probe_ev;

    decoder_scan #(.N(2), .DW(4)) dut2 (
        .clock(clock), .reset(reset), .a(a_in[1:0]), .load(load), .scan(scan),
        .dwell(dwell), .enable(enable), .active_low(active_low),
        .y(y2), .sel(sel2), .wrap(wrap2), .state(st2)
    );

    decoder_scan #(.N(3), .DW(4)) dut3 (
        .clock(clock), .reset(reset), .a(a_in), .load(load), .scan(scan),
        .dwell(dwell), .enable(enable), .active_low(active_low),
        .y(y3), .sel(sel3), .wrap(wrap3), .state(st3)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Inputs change just after a falling edge; they are sampled by the DUT on
    // the following rising edge.
    task automatic sync();
        @(negedge clock);
        #1;
    endtask

    task automatic push_exp(input logic which, input logic est, input logic ew,
                            input logic [2:0] es, input logic [7:0] ey);
        exp_q.push_back({which, est, ew, es, ey});
        tag_q.push_back(ntag);
        ntag++;
    endtask

    // Expected N=2 outputs after the coming rising edge.
    task automatic e2(input logic [3:0] ey, input logic [1:0] es, input logic ew,
                      input logic est);
        @(posedge clock);
        #1;
        push_exp(1'b0, est, ew, {1'b0, es}, {4'b0000, ey});
    endtask

    // Expected N=3 outputs after the coming rising edge.
    task automatic e3(input logic [7:0] ey, input logic [2:0] es, input logic ew,
                      input logic est);
        @(posedge clock);
        #1;
        push_exp(1'b1, est, ew, es, ey);
    endtask

    // Change polarity with no clock edge in between and check y at once.
    task automatic probe2(input logic al, input logic [3:0] ey, input logic [1:0] es);
        @(negedge clock);
        #1;
        active_low = al;
        #1;
        push_exp(1'b0, 1'b0, 1'b0, {1'b0, es}, {4'b0000, ey});
        -> probe_ev;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [13:0] exp_v;
    logic [13:0] act_v;
    int          tag_v;

    always begin
        @(negedge clock or probe_ev);
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            if (exp_v[13])
                act_v = {1'b1, st3, wrap3, sel3, y3};
            else
                act_v = {1'b0, st2, wrap2, 1'b0, sel2, 4'b0000, y2};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL chk%0d (N=%0d): got y=%b sel=%0d wrap=%b state=%b, expected y=%b sel=%0d wrap=%b state=%b",
                         tag_v, exp_v[13] ? 3 : 2,
                         act_v[7:0], act_v[10:8], act_v[11], act_v[12],
                         exp_v[7:0], exp_v[10:8], exp_v[11], exp_v[12]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        a_in       = '0;
        load       = 1'b0;
        scan       = 1'b0;
        dwell      = '0;
        enable     = 1'b1;
        active_low = 1'b0;

        // Reset state, both polarities.
        sync(); e2(4'b0000, 2'd0, 1'b0, 1'b0);
        sync(); active_low = 1'b1; e2(4'b1111, 2'd0, 1'b0, 1'b0);

        // Loads with active-high outputs.
        sync(); reset = 1'b0; active_low = 1'b0; load = 1'b1; a_in = 3'd0;
        e2(4'b0001, 2'd0, 1'b0, 1'b0);
        sync(); a_in = 3'd1; e2(4'b0010, 2'd1, 1'b0, 1'b0);
        sync(); a_in = 3'd2; e2(4'b0100, 2'd2, 1'b0, 1'b0);
        sync(); a_in = 3'd3; e2(4'b1000, 2'd3, 1'b0, 1'b0);

        // Same loads active-low.
        sync(); active_low = 1'b1; a_in = 3'd0; e2(4'b1110, 2'd0, 1'b0, 1'b0);
        sync(); a_in = 3'd1; e2(4'b1101, 2'd1, 1'b0, 1'b0);
        sync(); a_in = 3'd2; e2(4'b1011, 2'd2, 1'b0, 1'b0);
        sync(); a_in = 3'd3; e2(4'b0111, 2'd3, 1'b0, 1'b0);

        // Hold a=2, then flip polarity between edges.
        sync(); a_in = 3'd2; e2(4'b1011, 2'd2, 1'b0, 1'b0);
        sync(); load = 1'b0; e2(4'b1011, 2'd2, 1'b0, 1'b0);
        probe2(1'b0, 4'b0100, 2'd2);
        probe2(1'b1, 4'b1011, 2'd2);
        sync(); active_low = 1'b0; e2(4'b0100, 2'd2, 1'b0, 1'b0);

        // Scan with dwell=2 from 0: three cycles per output, wrap on 3->0.
        sync(); load = 1'b1; a_in = 3'd0; dwell = 4'd2; e2(4'b0001, 2'd0, 1'b0, 1'b0);
        sync(); load = 1'b0; scan = 1'b1; e2(4'b0001, 2'd0, 1'b0, 1'b1);
        for (int s = 1; s <= 4; s++) begin
            repeat (2) begin
                sync(); e2(4'b0001 << (s - 1), 2'(s - 1), 1'b0, 1'b1);
            end
            sync(); e2(4'b0001 << (s % 4), 2'(s % 4), (s == 4), 1'b1);
        end
        sync(); e2(4'b0001, 2'd0, 1'b0, 1'b1);

        // dwell=0: a step every cycle.
        sync(); dwell = 4'd0; e2(4'b0010, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b1);
        sync(); e2(4'b0001, 2'd0, 1'b1, 1'b1);

        // load with scan high: load wins, scan re-enters on the next cycle.
        sync(); load = 1'b1; a_in = 3'd2; e2(4'b0100, 2'd2, 1'b0, 1'b0);
        sync(); load = 1'b0; e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b1);
        sync(); e2(4'b0001, 2'd0, 1'b1, 1'b1);

        // Disable mid-scan: outputs dark, select keeps stepping.
        sync(); dwell = 4'd2; e2(4'b0001, 2'd0, 1'b0, 1'b1);
        sync(); enable = 1'b0; e2(4'b0000, 2'd0, 1'b0, 1'b1);
        sync(); e2(4'b0000, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0000, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0000, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0000, 2'd2, 1'b0, 1'b1);
        sync(); enable = 1'b1; e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b1);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b1);

        // Reset at sel=3, cnt=1 with scan still requested.
        sync(); reset = 1'b1; e2(4'b0000, 2'd0, 1'b0, 1'b0);
        sync(); reset = 1'b0; scan = 1'b0; e2(4'b0001, 2'd0, 1'b0, 1'b0);

        // Loading 0 from 3 is not a wrap.
        sync(); load = 1'b1; a_in = 3'd3; e2(4'b1000, 2'd3, 1'b0, 1'b0);
        sync(); a_in = 3'd0; e2(4'b0001, 2'd0, 1'b0, 1'b0);

        // Lowering dwell below the running count advances at once.
        sync(); a_in = 3'd1; dwell = 4'd5; e2(4'b0010, 2'd1, 1'b0, 1'b0);
        sync(); load = 1'b0; scan = 1'b1; e2(4'b0010, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0010, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0010, 2'd1, 1'b0, 1'b1);
        sync(); e2(4'b0010, 2'd1, 1'b0, 1'b1);
        sync(); dwell = 4'd1; e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b0100, 2'd2, 1'b0, 1'b1);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b1);

        // Leaving scan freezes the current output.
        sync(); scan = 1'b0; e2(4'b1000, 2'd3, 1'b0, 1'b0);
        sync(); e2(4'b1000, 2'd3, 1'b0, 1'b0);

        // N=3 walk with dwell=2: eight outputs, wrap on 7->0.
        sync(); reset = 1'b1; e3(8'h00, 3'd0, 1'b0, 1'b0);
        sync(); reset = 1'b0; load = 1'b1; a_in = 3'd0; dwell = 4'd2;
        e3(8'h01, 3'd0, 1'b0, 1'b0);
        sync(); load = 1'b0; scan = 1'b1; e3(8'h01, 3'd0, 1'b0, 1'b1);
        for (int s = 1; s <= 8; s++) begin
            repeat (2) begin
                sync(); e3(8'h01 << (s - 1), 3'(s - 1), 1'b0, 1'b1);
            end
            sync(); e3(8'h01 << (s % 8), 3'(s % 8), (s == 8), 1'b1);
        end
        sync(); e3(8'h01, 3'd0, 1'b0, 1'b1);

        // Let the monitor drain the queue.
        sync();
        sync();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N line decoder, the next generation of the team's 2-to-4 combinational decoder.
- Keeps the run-time output-polarity select.
- Adds:
  - a registered load path;
  - an output enable;
  - an auto-scan mode in which a walking-one steps through all outputs with a programmable dwell time.
- Drives strobe/select lines for multiplexed displays and row scanners.

Parameters:
- N, 2, select width; output width is 2**N (legal range 1..6).
- DW, 4, dwell counter width; dwell is 0..2**DW-1 extra cycles per output.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a  input  N  select value captured on load.
- load  input  1  capture a into the select register.
- scan  input  1  auto-scan mode request.
- dwell  input  DW  extra cycles each output stays active in scan mode.
- enable  input  1  output enable; 0 forces all outputs inactive.
- active_low  input  1  output polarity; 1 = active-low outputs.
- y  output  2**N  decoded outputs.
- sel  output  N  current select register value.
- wrap  output  1  one-cycle pulse when scan wraps from 2**N-1 to 0.

Behaviour:
- **Registers**
  - sel_q (N bits), onehot_q (2**N bits), dwell counter cnt (DW bits), wrap_q, and state in {HOLD, SCAN}.
- **Reset** (synchronous, sampled on the clock edge; overrides all other inputs)
  - sel_q=0, onehot_q=0, cnt=0, wrap_q=0, state=HOLD.
  - Consequently y = all active_low (all outputs inactive), sel=0, wrap=0.
- **Output polarity**
  - y = onehot_q XOR {2**N{active_low}}.
  - Combinational, so a change of active_low is visible in the same cycle with no register latency.
- **Input priority at each edge:** reset > load > scan > hold.
- **load=1**
  - sel_q<=a, cnt<=0, state<=HOLD.
  - onehot_q<=(1<<a) if enable, else 0.
  - Latency: y reflects a one cycle after load is sampled.
  - load beats scan when both are high; scan takes effect on the next cycle if it is still high.
- **HOLD** (load=0, scan=0)
  - sel_q and cnt hold.
  - onehot_q<=enable ? (1<<sel_q) : 0.
- **HOLD -> SCAN**
  - Taken when scan=1 and load=0; cnt<=0.
  - The first advance occurs dwell+1 cycles later, so the current output is shown for a full dwell period.
- **SCAN** (scan=1, load=0)
  - If cnt==dwell: sel_q<=sel_q+1 (modulo 2**N), cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Each output is active for exactly dwell+1 cycles; dwell=0 advances every cycle.
  - dwell is sampled live each cycle. If dwell is reduced below cnt, cnt==dwell is never reached before cnt itself wraps; to avoid this, the comparison is cnt>=dwell.
- **wrap**
  - wrap_q<=1 for exactly one cycle on the same edge where sel_q goes 2**N-1 -> 0 in SCAN; 0 otherwise.
  - Never asserted by load, even when loading 0.
- **SCAN -> HOLD**
  - On scan=0: sel_q and cnt freeze, and the current output stays active.
- **enable=0**
  - onehot_q<=0 on the next edge.
  - sel_q, cnt and state continue to update, so scanning keeps running invisibly.
  - On re-enable, onehot_q<=1<<sel_q on the next edge.
- **N=1**
  - Degenerates to a 1-to-2 decoder; the modulo and wrap rules are unchanged.
- **Reset mid-scan**
  - Takes effect at the next edge regardless of cnt.
  - No wrap pulse is generated.

Test Plan:
1. N=2, active_low=0, enable=1: load a=0,1,2,3 on successive cycles -> y=0001,0010,0100,1000 each one cycle after load; sel matches a.
2. Same sequence with active_low=1 -> y=1110,1101,1011,0111. Toggle active_low mid-hold with a=2 -> y flips 0100<->1011 in the same cycle.
3. N=2, dwell=2: load a=0, then scan=1 -> each output active 3 cycles, order 0001,0010,0100,1000,0001. wrap=1 for exactly the cycle where sel first returns to 0; 12-cycle period.
4. dwell=0 scan -> y changes every cycle. Assert load a=2 together with scan -> y=0100 next cycle, then scanning resumes from 2 (0100 then 1000 one cycle later).
5. Mid-scan, enable=0 for 5 cycles -> y=0000. On re-enable, y shows 1<<sel where sel advanced during disable, consistent with the dwell schedule.
6. Assert reset mid-scan with sel=3, cnt=1 -> next cycle y=0000, sel=0, wrap=0, state HOLD. With N=3, repeat test 3 -> 8 outputs walk and wrap at sel=7->0.
